// File: rtl/alu_8_arbiter.sv
// Two-requester front end for a shared combinational alu_8: arbitrates, latches
// operands, waits one EXEC cycle, then holds the result until the owner takes it.
module alu_8_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_opcode,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_opcode,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_reg, state_next;
  logic [7:0] a_reg, b_reg, result_reg;
  logic [3:0] opcode_reg;
  logic       owner_reg, last_grant_reg;
  logic       grant0, grant1;
  logic       rsp_taken;

  // Grants only exist in IDLE; on a tie round-robin favours whoever did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE) begin
      if (FIXED_PRIORITY != 0) begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
      end else if (req0_valid && req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = ~last_grant_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign rsp_taken = owner_reg ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant0 || grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_taken) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      a_reg          <= 8'd0;
      b_reg          <= 8'd0;
      opcode_reg     <= 4'd0;
      result_reg     <= 8'd0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (grant0 || grant1) begin
        a_reg          <= grant1 ? req1_a : req0_a;
        b_reg          <= grant1 ? req1_b : req0_b;
        opcode_reg     <= grant1 ? req1_opcode : req0_opcode;
        owner_reg      <= grant1;
        last_grant_reg <= grant1;
      end
      if (state_reg == EXEC) result_reg <= alu_out;
    end
  end

  // ALU inputs come straight from the operand registers so they never glitch mid-EXEC.
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_opcode = opcode_reg;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid = (state_reg == RESP) && owner_reg;
  assign rsp0_data  = result_reg;
  assign rsp1_data  = result_reg;

endmodule

// File: tb/tb_alu_8_arbiter.sv
// Scoreboard bench for alu_8_arbiter: one round-robin and one fixed-priority
// instance, exercised one at a time while the other is held in reset.
module tb_alu_8_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_rr, reset_fp, sel_fp;
  logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_opcode, req1_opcode;

  logic       rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
  logic [7:0] rr_rsp0_data, rr_rsp1_data, rr_alu_a, rr_alu_b, rr_alu_out;
  logic [3:0] rr_alu_opcode;
  logic       fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [7:0] fp_rsp0_data, fp_rsp1_data, fp_alu_a, fp_alu_b, fp_alu_out;
  logic [3:0] fp_alu_opcode;

  logic       m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid, m_reset;
  logic [7:0] m_rsp0_data, m_rsp1_data, m_alu_a, m_alu_b;
  logic [3:0] m_alu_opcode;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  // Bench model of alu_8: 0 add, 1 sub, 2 and, 3 or, others xor.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign rr_alu_out = alu_model(rr_alu_opcode, rr_alu_a, rr_alu_b);
  assign fp_alu_out = alu_model(fp_alu_opcode, fp_alu_a, fp_alu_b);

  alu_8_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset_rr),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode), .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rr_rsp0_data),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode), .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rr_rsp1_data),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_opcode(rr_alu_opcode), .alu_out(rr_alu_out)
  );

  alu_8_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset_fp),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode), .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fp_rsp0_data),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode), .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fp_rsp1_data),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_opcode(fp_alu_opcode), .alu_out(fp_alu_out)
  );

  assign m_reset      = sel_fp ? reset_fp      : reset_rr;
  assign m_req0_ready = sel_fp ? fp_req0_ready : rr_req0_ready;
  assign m_req1_ready = sel_fp ? fp_req1_ready : rr_req1_ready;
  assign m_rsp0_valid = sel_fp ? fp_rsp0_valid : rr_rsp0_valid;
  assign m_rsp1_valid = sel_fp ? fp_rsp1_valid : rr_rsp1_valid;
  assign m_rsp0_data  = sel_fp ? fp_rsp0_data  : rr_rsp0_data;
  assign m_rsp1_data  = sel_fp ? fp_rsp1_data  : rr_rsp1_data;
  assign m_alu_a      = sel_fp ? fp_alu_a      : rr_alu_a;
  assign m_alu_b      = sel_fp ? fp_alu_b      : rr_alu_b;
  assign m_alu_opcode = sel_fp ? fp_alu_opcode : rr_alu_opcode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input logic owner, input logic [7:0] data);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_rsp: got owner %0d data %0d, required no response (t=%0t)", owner, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("rsp_owner", {31'd0, owner}, {31'd0, e[8]});
      check("rsp_data", {24'd0, data}, {24'd0, e[7:0]});
      $display("rsp owner=%0d data=%0d expected owner=%0d data=%0d", owner, data, e[8], e[7:0]);
    end
  endtask

  // Monitor: every consumed response is matched against the scoreboard.
  always @(negedge clk) begin
    if (!m_reset) begin
      if (m_rsp0_valid && m_rsp1_valid) check("rsp_exclusive", 32'd1, 32'd0);
      if (m_rsp0_valid && rsp0_ready) pop_check(1'b0, m_rsp0_data);
      if (m_rsp1_valid && rsp1_ready) pop_check(1'b1, m_rsp1_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] o0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] o1);
    req0_a = a0; req0_b = b0; req0_opcode = o0;
    req1_a = a1; req1_b = b1; req1_opcode = o1;
  endtask

  // Leaves the selected instance just out of reset, the other held in reset.
  task automatic do_reset(input logic fp);
    sel_fp = fp;
    reset_rr = 1'b1; reset_fp = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    step();
    reset_rr = fp;
    reset_fp = !fp;
  endtask

  // One full IDLE -> EXEC -> RESP transaction with the responder ready.
  task automatic op_cycle(input logic g, input logic [7:0] e, input string tag);
    @(negedge clk);
    check({tag, "_req0_ready"}, {31'd0, m_req0_ready}, {31'd0, !g});
    check({tag, "_req1_ready"}, {31'd0, m_req1_ready}, {31'd0, g});
    exp_q.push_back({g, e});
    $display("%s: grant %0d expect %0d", tag, g, e);
    step();
    @(negedge clk);
    check({tag, "_exec_ready"}, {30'd0, m_req1_ready, m_req0_ready}, 32'd0);
    check({tag, "_exec_valid"}, {30'd0, m_rsp1_valid, m_rsp0_valid}, 32'd0);
    step();
    @(negedge clk);
    check({tag, "_resp_valid"}, {30'd0, m_rsp1_valid, m_rsp0_valid}, g ? 32'd2 : 32'd1);
    check({tag, "_resp_ready"}, {30'd0, m_req1_ready, m_req0_ready}, 32'd0);
    step();
  endtask

  localparam logic [7:0] T_A0 [6] = '{8'd10, 8'hF0, 8'hF0, 8'd0, 8'd255, 8'd0};
  localparam logic [7:0] T_B0 [6] = '{8'd20, 8'h3C, 8'h3C, 8'd0, 8'd1, 8'd0};
  localparam logic [3:0] T_O0 [6] = '{4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0};
  localparam logic [7:0] T_A1 [6] = '{8'd50, 8'd50, 8'h0F, 8'h0F, 8'd3, 8'd3};
  localparam logic [7:0] T_B1 [6] = '{8'd5, 8'd5, 8'hF0, 8'hF0, 8'd5, 8'd5};
  localparam logic [3:0] T_O1 [6] = '{4'd1, 4'd1, 4'd3, 4'd3, 4'd1, 4'd1};
  localparam logic       T_G  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] T_E  [6] = '{8'd30, 8'd45, 8'd48, 8'd255, 8'd0, 8'd254};

  localparam logic [7:0] F_A0 [3] = '{8'd1, 8'd100, 8'd9};
  localparam logic [7:0] F_B0 [3] = '{8'd1, 8'd200, 8'd3};
  localparam logic [3:0] F_O0 [3] = '{4'd0, 4'd0, 4'd1};
  localparam logic [7:0] F_E  [3] = '{8'd2, 8'd44, 8'd6};

  initial begin
    sel_fp = 1'b0;
    reset_rr = 1'b1; reset_fp = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_ops(8'd0, 8'd0, 4'd0, 8'd0, 8'd0, 4'd0);

    // Reset values
    do_reset(1'b0);
    @(negedge clk);
    check("reset_rsp_valid", {30'd0, m_rsp1_valid, m_rsp0_valid}, 32'd0);
    check("reset_alu", {12'd0, m_alu_a, m_alu_b, m_alu_opcode}, 32'd0);
    check("reset_ready_noreq", {30'd0, m_req1_ready, m_req0_ready}, 32'd0);

    // Single requester, 7 + 7
    step();
    set_ops(8'd7, 8'd7, 4'd0, 8'd0, 8'd0, 4'd0);
    req0_valid = 1'b1;
    op_cycle(1'b0, 8'd14, "single0");
    req0_valid = 1'b0;
    @(negedge clk);
    check("single0_idle_valid", {30'd0, m_rsp1_valid, m_rsp0_valid}, 32'd0);

    // Round-robin with both requesters always valid
    do_reset(1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ops(T_A0[i], T_B0[i], T_O0[i], T_A1[i], T_B1[i], T_O1[i]);
      op_cycle(T_G[i], T_E[i], "rr");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure on requester 1: 200 + 100 = 44
    do_reset(1'b0);
    set_ops(8'd5, 8'd6, 4'd0, 8'd200, 8'd100, 4'd0);
    req1_valid = 1'b1; rsp1_ready = 1'b0;
    @(negedge clk);
    check("bp_req1_ready", {31'd0, m_req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'd44});
    step();
    req1_valid = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    check("bp_exec_valid", {31'd0, m_rsp1_valid}, 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, m_rsp1_valid}, 32'd1);
      check("bp_hold_data", {24'd0, m_rsp1_data}, 32'd44);
      check("bp_hold_req0_ready", {31'd0, m_req0_ready}, 32'd0);
      $display("bp hold cycle %0d: rsp1_valid=%0d data=%0d", k, m_rsp1_valid, m_rsp1_data);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, m_rsp1_valid}, 32'd1);
    check("bp_release_req0_ready", {31'd0, m_req0_ready}, 32'd0);
    step();
    op_cycle(1'b0, 8'd11, "bp_next");
    req0_valid = 1'b0;

    // Reset while the operation is in EXEC
    do_reset(1'b0);
    set_ops(8'd1, 8'd2, 4'd0, 8'd4, 8'd4, 4'd0);
    req0_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", {31'd0, m_req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("rst_exec_alu_a", {24'd0, m_alu_a}, 32'd1);
    reset_rr = 1'b1;
    step();
    reset_rr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_after_valid", {30'd0, m_rsp1_valid, m_rsp0_valid}, 32'd0);
      check("rst_after_alu", {12'd0, m_alu_a, m_alu_b, m_alu_opcode}, 32'd0);
      check("rst_after_ready", {30'd0, m_req1_ready, m_req0_ready}, 32'd0);
      step();
    end
    set_ops(8'd9, 8'd9, 4'd0, 8'd4, 8'd4, 4'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    op_cycle(1'b0, 8'd18, "rst_next");
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Fixed priority: requester 0 always wins
    do_reset(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(F_A0[i], F_B0[i], F_O0[i], 8'd77, 8'd1, 4'd0);
      op_cycle(1'b0, F_E[i], "fp");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    step();
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_8_arbiter.md
ALU_8_ARBITER -- requirements
Module: alu_8_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, default 0, 0 = round-robin grant, 1 = requester 0 always wins ties.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-008 req0_opcode  input  4  requester 0 ALU opcode.
REQ-009 rsp0_valid  output  1  result for requester 0 available.
REQ-010 rsp0_ready  input  1  requester 0 consumes result.
REQ-011 rsp0_data  output  8  result for requester 0.
REQ-012 req1_valid, req1_ready, req1_a, req1_b, req1_opcode, rsp1_valid, rsp1_ready, rsp1_data: same directions, widths and meanings for requester 1.
REQ-013 alu_a, alu_b  output  8 each  operands to the shared combinational alu_8.
REQ-014 alu_opcode  output  4  opcode to the shared alu_8.
REQ-015 alu_out  input  8  alu_8 result, combinational in alu_a/alu_b/alu_opcode.

Function
REQ-016 FSM states IDLE, EXEC and RESP; exactly one operation in flight.
REQ-017 IDLE: grant computed combinationally from req0_valid, req1_valid, FIXED_PRIORITY and last_grant; reqN_ready = 1 only for the granted requester, only in IDLE.
REQ-018 Transfer occurs on reqN_valid & reqN_ready; the same edge latches a, b, opcode into operand registers, records owner = N, updates last_grant = N, moves to EXEC.
REQ-019 IDLE with no valid request: remain in IDLE; operand registers, owner and last_grant unchanged.
REQ-020 Round-robin (FIXED_PRIORITY=0): single valid requester wins; both valid -> requester != last_grant wins.
REQ-021 FIXED_PRIORITY=1: requester 0 wins whenever req0_valid = 1; last_grant still updated.
REQ-022 alu_a, alu_b, alu_opcode are driven from the operand registers in all states, so ALU inputs are stable for the whole EXEC cycle.
REQ-023 EXEC lasts exactly one cycle; at its end alu_out is captured into the result register and the state moves to RESP.
REQ-024 Latency: request accepted on edge t -> rspN_valid = 1 during cycle t+2 (two cycles after acceptance).
REQ-025 RESP: rsp{owner}_valid = 1, rsp{owner}_data = result register; the other rsp valid = 0.
REQ-026 RESP holds valid and data stable until rsp{owner}_ready = 1; then move to IDLE on that edge.
REQ-027 rspN_ready while rspN_valid = 0 has no effect.
REQ-028 No request is accepted in EXEC or RESP (both reqN_ready = 0); minimum interval between acceptances is 3 cycles.
REQ-029 rspN_data outside RESP for owner N holds the result register value (don't-care for consumers).
REQ-030 Requester changing operands while reqN_valid = 1 and not yet accepted: the values present on the accepting edge are used.

Reset
REQ-031 reset = 1 on a rising edge: state = IDLE, operand registers = 0, result register = 0, owner = 0, last_grant = 1; takes priority over all other events.
REQ-032 After reset: all reqN_ready follow REQ-017 in IDLE; rsp0_valid = rsp1_valid = 0; alu_a = alu_b = 0, alu_opcode = 0.
REQ-033 Reset during EXEC or RESP: the in-flight operation is discarded without any response; the next cycle is IDLE.

Verification (bench models alu_8 opcode 0 as a + b mod 256)
REQ-034 Reset, then req0 a=7, b=7, op=0 alone, rsp0_ready = 1 -> req0_ready = 1 in cycle 0, rsp0_valid = 1 with rsp0_data = 14 two cycles later, rsp1_valid stays 0.
REQ-035 Both requesters valid continuously after reset, FIXED_PRIORITY=0, rsp ready tied 1 -> grants alternate 0,1,0,1, one acceptance every 3 cycles.
REQ-036 FIXED_PRIORITY=1, both valid continuously -> requester 0 wins every arbitration; req1_ready never 1.
REQ-037 Back-pressure: rsp1_ready = 0 for 5 cycles after rsp1_valid rises, with a=200, b=100, op=0 -> rsp1_data = 44 held stable for all 5 cycles, req0_ready = 0 throughout, IDLE one cycle after rsp1_ready rises.
REQ-038 reset asserted during EXEC -> no rsp valid ever appears for that operation; the next cycle is IDLE with all outputs at reset values.
